cache_refill_ctrl: RTL
======================

Name: cache_refill_ctrl

Overview:
AXI-side companion to the 2-way cache tag block. It consumes the tag block's miss, write_back, raddr and waddr outputs, and handles uncached requests. It optionally writes back the victim 64-byte line as a 16-beat burst, then refills the line with a 16-beat read burst into the data array. It pulses refresh so the tag block installs the new tag. Uncached accesses are served as single-beat reads.

Parameters:
LINE_WORDS, 16, words per cache line (burst length = LINE_WORDS-1 in *len)
IDX_W, 4, log2(LINE_WORDS), width of word index
DATA_W, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss  in  1  cached miss from tag block (held until refresh takes effect)
write_back  in  1  victim line valid, must be written back first
raddr  in  32  refill address (line aligned when cached, word address when uncached)
waddr  in  32  victim line address
uc_req  in  1  uncached read request (uses raddr)
refresh  out  1  one-cycle pulse: tag block installs new tag
uc_valid  out  1  one-cycle pulse: uc_rdata valid
uc_rdata  out  32  uncached read data
line_we  out  1  data array refill write enable
line_widx  out  IDX_W  refill word index
line_wdata  out  32  refill word
wb_ridx  out  IDX_W  victim word index (data array read, combinational)
wb_rdata  in  32  victim word, valid in the same cycle as wb_ridx
arvalid/arready  out/in  1  read address handshake
araddr  out  32 ; arlen  out  8
rvalid/rready  in/out  1 ; rdata  in  32 ; rlast  in  1
awvalid/awready  out/in  1 ; awaddr  out  32 ; awlen  out  8
wvalid/wready  out/in  1 ; wdata  out  32 ; wlast  out  1
bvalid/bready  in/out  1

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. On reset the state is IDLE, beat counter = 0, and every valid/ready/we/refresh/uc_valid output = 0; uc_rdata = 0. Reset mid-burst abandons the transaction immediately with no completion pulses.
- FSM states: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
- IDLE: on miss the block latches raddr, waddr and write_back, and sets is_cached=1. If write_back=1 it goes to WB_AW, otherwise to RD_AR. Otherwise, on uc_req it latches raddr, sets is_cached=0 and goes to RD_AR. miss has priority over uc_req.
- WB_AW: awvalid=1, awaddr=latched waddr, awlen=LINE_WORDS-1. On awready: cnt<=0 and go to WB_W.
- WB_W: wvalid=1, wb_ridx=cnt, wdata=wb_rdata, wlast=(cnt==LINE_WORDS-1). On wready: cnt++. If the handshaked beat has wlast=1, go to WB_B. While wready=0, cnt and wdata hold.
- WB_B: bready=1. On bvalid go to RD_AR. bresp is ignored.
- RD_AR: arvalid=1, araddr=latched raddr, arlen = is_cached ? LINE_WORDS-1 : 0. On arready: cnt<=0 and go to RD_R.
- RD_R: rready=1. On rvalid:
  - Cached: line_we=1, line_widx=cnt, line_wdata=rdata (combinational, same cycle), cnt++. line_we is suppressed once LINE_WORDS beats have been written; extra beats are dropped.
  - Uncached: uc_rdata<=rdata.
  - Exit to DONE on rvalid&rlast only, regardless of beat count.
- DONE (1 cycle): refresh=is_cached, uc_valid=~is_cached, then go to IDLE.
- Tag update timing: the tag block updates on the DONE clock edge, so miss is low in the following IDLE cycle. The uncached requester must drop uc_req in the cycle after uc_valid.
- Ordering and abort: valid outputs never drop before their handshake. The AXI valid signals depend only on state, never combinationally on ready. No abort: flush does not interrupt a started transaction.
- Latency, no wait states, cached miss without write-back: IDLE→RD_AR→RD_R(16)→DONE = refresh 19 cycles after miss is seen.
- cnt is IDX_W+1 bits wide so that "LINE_WORDS written" is detectable.

Test Plan:
- Clean miss, write_back=0, raddr=0x1FC0_0040, all readies=1, rdata=beat number → arlen=15, araddr=0x1FC0_0040; line_widx 0..15 with line_wdata 0..15; single refresh pulse; no AW/W activity.
- Miss with write_back=1, waddr=0x0000_1080 → awaddr=0x0000_1080, awlen=15; wdata follows wb_ridx 0..15 with wlast on beat 15; AR issued only after the bvalid handshake.
- uc_req, raddr=0xBFAF_8004, rdata=0xDEAD_BEEF with rlast → arlen=0; uc_valid pulse with uc_rdata=0xDEAD_BEEF; refresh stays 0; line_we stays 0.
- Backpressure: wready toggled 1/0 and arready delayed 5 cycles, rvalid with gaps → wdata and wb_ridx stable while stalled; exactly 16 line_we pulses; refresh once.
- rst asserted during beat 7 of WB_W → next cycle IDLE with all valids 0; a new miss restarts at WB_AW with cnt=0.
- miss and uc_req simultaneous → cached path served first; uc_req is served after the DONE→IDLE return.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: AXI-side companion to the 2-way cache tag block.
//
// On a cached miss it optionally writes the victim line back as a LINE_WORDS-beat
// AXI write burst (data read combinationally from the data array through wb_ridx_o /
// wb_rdata_i), then refills the line with a LINE_WORDS-beat AXI read burst into the
// data array (line_we_o / line_widx_o / line_wdata_o). A one-cycle refresh_o pulse
// lets the tag block install the new tag. Uncached reads (uc_req_i) are served as
// single-beat AXI reads returned on uc_rdata_o with a one-cycle uc_valid_o pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   miss_i, write_back_i     cached miss / victim-dirty indication from the tag block
//   raddr_i, waddr_i         refill (or uncached word) address, victim line address
//   uc_req_i                 uncached read request (uses raddr_i)
//   refresh_o, uc_valid_o    completion pulses
//   uc_rdata_o               uncached read data
//   line_*_o                 data array refill write port
//   wb_ridx_o, wb_rdata_i    data array victim read port
//   ar*/r*/aw*/w*/b*         AXI master channels (no id, no resp checking)

module cache_refill_ctrl #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_i,
    input  logic              write_back_i,
    input  logic [DATA_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] waddr_i,
    input  logic              uc_req_i,
    output logic              refresh_o,
    output logic              uc_valid_o,
    output logic [DATA_W-1:0] uc_rdata_o,
    output logic              line_we_o,
    output logic [IDX_W-1:0]  line_widx_o,
    output logic [DATA_W-1:0] line_wdata_o,
    output logic [IDX_W-1:0]  wb_ridx_o,
    input  logic [DATA_W-1:0] wb_rdata_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [DATA_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rlast_i,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wlast_o,
    input  logic              bvalid_i,
    output logic              bready_o
);

    // One extra counter bit so that "LINE_WORDS beats written" is representable.
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [7:0]       LEN_LINE = 8'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWbAw,
        StWbW,
        StWbB,
        StRdAr,
        StRdR,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] waddr_q, waddr_d;
    logic              cached_q, cached_d;
    logic [DATA_W-1:0] uc_rdata_q, uc_rdata_d;
    logic              w_is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            cached_q   <= 1'b0;
            uc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            cached_q   <= cached_d;
            uc_rdata_q <= uc_rdata_d;
        end
    end

    assign w_is_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        cached_d   = cached_q;
        uc_rdata_d = uc_rdata_q;

        refresh_o    = 1'b0;
        uc_valid_o   = 1'b0;
        uc_rdata_o   = uc_rdata_q;
        line_we_o    = 1'b0;
        line_widx_o  = cnt_q[IDX_W-1:0];
        line_wdata_o = rdata_i;
        wb_ridx_o    = cnt_q[IDX_W-1:0];
        arvalid_o    = 1'b0;
        araddr_o     = raddr_q;
        arlen_o      = cached_q ? LEN_LINE : 8'd0;
        rready_o     = 1'b0;
        awvalid_o    = 1'b0;
        awaddr_o     = waddr_q;
        awlen_o      = LEN_LINE;
        wvalid_o     = 1'b0;
        wdata_o      = wb_rdata_i;
        wlast_o      = 1'b0;
        bready_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Cached miss wins over an uncached request.
                if (miss_i) begin
                    raddr_d  = raddr_i;
                    waddr_d  = waddr_i;
                    cached_d = 1'b1;
                    state_d  = write_back_i ? StWbAw : StRdAr;
                end else if (uc_req_i) begin
                    raddr_d  = raddr_i;
                    cached_d = 1'b0;
                    state_d  = StRdAr;
                end
            end
            StWbAw: begin
                awvalid_o = 1'b1;
                if (awready_i) begin
                    cnt_d   = '0;
                    state_d = StWbW;
                end
            end
            StWbW: begin
                wvalid_o = 1'b1;
                wlast_o  = w_is_last;
                if (wready_i) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (w_is_last) begin
                        state_d = StWbB;
                    end
                end
            end
            StWbB: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_d = StRdAr;
                end
            end
            StRdAr: begin
                arvalid_o = 1'b1;
                if (arready_i) begin
                    cnt_d   = '0;
                    state_d = StRdR;
                end
            end
            StRdR: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    if (cached_q) begin
                        // Beats beyond a full line are accepted but dropped.
                        if (cnt_q < CNT_FULL) begin
                            line_we_o = 1'b1;
                            cnt_d     = cnt_q + CNT_ONE;
                        end
                    end else begin
                        uc_rdata_d = rdata_i;
                    end
                    // Completion follows rlast, not the beat count.
                    if (rlast_i) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                refresh_o  = cached_q;
                uc_valid_o = ~cached_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
